// File: rtl/calc_core_seq.sv
// rtl/calc_core_seq.sv - sequential add/sub/mul/div/mod engine with double-dabble BCD output
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, a, b     request, op code (0 add,1 sub,2 mul,3 div,4 mod), unsigned operands
//   busy, done          operation in flight, one-cycle completion pulse
//   result, bcd         binary magnitude (2*WIDTH bits) and its BCD digits (digit 0 in [3:0])
//   neg, div_by_zero,   sub with a<b, div/mod by zero, illegal op code
//   op_err
module calc_core_seq #(
  parameter int WIDTH      = 8,
  parameter int BCD_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0]              op,
  input  logic [WIDTH-1:0]        a,
  input  logic [WIDTH-1:0]        b,
  output logic                    busy,
  output logic                    done,
  output logic [2*WIDTH-1:0]      result,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    neg,
  output logic                    div_by_zero,
  output logic                    op_err
);

  localparam int RW = 2 * WIDTH;
  localparam int BW = 4 * BCD_DIGITS;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CONV} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  // a_q: multiplicand (shifted left) for mul, dividend/quotient shift register for div/mod
  logic [RW-1:0]   a_q, a_d;
  // b_q: multiplier (shifted right) for mul, divisor otherwise
  logic [WIDTH-1:0] b_q, b_d;
  // work_q: mul accumulator / div partial remainder, then holds the final result during CONV
  logic [RW-1:0]   work_q, work_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   bin_q, bin_d;
  logic [BW-1:0]   dd_q, dd_d;
  logic            neg_p_q, neg_p_d, dbz_p_q, dbz_p_d, err_p_q, err_p_d;
  logic [RW-1:0]   result_q, result_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_q, neg_d, dbz_q, dbz_d, err_q, err_d, done_q, done_d;

  logic [RW-1:0]    mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [BW-1:0]    dd_adj;
  logic [RW-1:0]    exec_res;
  logic             exec_fin, f_neg, f_dbz, f_err;

  // One datapath step for each iterative op, selected by the FSM below.
  always_comb begin
    mul_acc = work_q + (b_q[0] ? a_q : '0);
    rem_sh  = {work_q[WIDTH-1:0], a_q[WIDTH-1]};
    div_ge  = (rem_sh >= {1'b0, b_q});
    // When the trial subtract fails the shifted remainder is below b, so its MSB is 0.
    rem_nx  = div_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
    quo_nx  = {a_q[WIDTH-2:0], div_ge};
  end

  // Double-dabble correction: every digit >=5 gets +3 before the shift.
  always_comb begin
    dd_adj = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      dd_adj[4*i +: 4] = (dd_q[4*i +: 4] >= 4'd5) ? dd_q[4*i +: 4] + 4'd3 : dd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d  = state_q;   op_d    = op_q;    a_d     = a_q;     b_d     = b_q;
    work_d   = work_q;    cnt_d   = cnt_q;   bin_d   = bin_q;   dd_d    = dd_q;
    neg_p_d  = neg_p_q;   dbz_p_d = dbz_p_q; err_p_d = err_p_q;
    result_d = result_q;  bcd_d   = bcd_q;   neg_d   = neg_q;   dbz_d   = dbz_q;
    err_d    = err_q;     done_d  = 1'b0;
    exec_res = '0;        exec_fin = 1'b0;   f_neg = 1'b0;      f_dbz = 1'b0;
    f_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = {{WIDTH{1'b0}}, a};
          b_d     = b;
          work_d  = '0;
          cnt_d   = '0;
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        case (op_q)
          3'd0: begin
            exec_res = a_q + {{WIDTH{1'b0}}, b_q};
            exec_fin = 1'b1;
          end
          3'd1: begin
            if (a_q[WIDTH-1:0] >= b_q) begin
              exec_res = RW'(a_q[WIDTH-1:0] - b_q);
            end else begin
              exec_res = RW'(b_q - a_q[WIDTH-1:0]);
              f_neg    = 1'b1;
            end
            exec_fin = 1'b1;
          end
          3'd2: begin
            work_d   = mul_acc;
            a_d      = a_q << 1;
            b_d      = b_q >> 1;
            exec_res = mul_acc;
            exec_fin = (cnt_q == CW'(WIDTH - 1));
          end
          3'd3, 3'd4: begin
            if (b_q == '0) begin
              exec_res = (op_q == 3'd3) ? RW'({WIDTH{1'b1}}) : a_q;
              f_dbz    = 1'b1;
              exec_fin = 1'b1;
            end else begin
              work_d   = RW'(rem_nx);
              a_d      = RW'(quo_nx);
              exec_res = (op_q == 3'd3) ? RW'(quo_nx) : RW'(rem_nx);
              exec_fin = (cnt_q == CW'(WIDTH - 1));
            end
          end
          default: begin
            exec_res = '0;
            f_err    = 1'b1;
            exec_fin = 1'b1;
          end
        endcase
        if (exec_fin) begin
          work_d  = exec_res;
          bin_d   = exec_res;
          dd_d    = '0;
          cnt_d   = '0;
          neg_p_d = f_neg;
          dbz_p_d = f_dbz;
          err_p_d = f_err;
          state_d = S_CONV;
        end
      end

      S_CONV: begin
        // RW shift cycles, then one cycle that publishes every output together.
        if (cnt_q == CW'(RW)) begin
          result_d = work_q;
          bcd_d    = dd_q;
          neg_d    = neg_p_q;
          dbz_d    = dbz_p_q;
          err_d    = err_p_q;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          dd_d  = {dd_adj[BW-2:0], bin_q[RW-1]};
          bin_d = bin_q << 1;
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE; op_q    <= '0;   a_q     <= '0;   b_q     <= '0;
      work_q   <= '0;     cnt_q   <= '0;   bin_q   <= '0;   dd_q    <= '0;
      neg_p_q  <= 1'b0;   dbz_p_q <= 1'b0; err_p_q <= 1'b0;
      result_q <= '0;     bcd_q   <= '0;   neg_q   <= 1'b0; dbz_q   <= 1'b0;
      err_q    <= 1'b0;   done_q  <= 1'b0;
    end else begin
      state_q  <= state_d;  op_q    <= op_d;    a_q     <= a_d;     b_q     <= b_d;
      work_q   <= work_d;   cnt_q   <= cnt_d;   bin_q   <= bin_d;   dd_q    <= dd_d;
      neg_p_q  <= neg_p_d;  dbz_p_q <= dbz_p_d; err_p_q <= err_p_d;
      result_q <= result_d; bcd_q   <= bcd_d;   neg_q   <= neg_d;   dbz_q   <= dbz_d;
      err_q    <= err_d;    done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign bcd         = bcd_q;
  assign neg         = neg_q;
  assign div_by_zero = dbz_q;
  assign op_err      = err_q;

endmodule

// File: tb/tb_calc_core_seq.sv
// tb/tb_calc_core_seq.sv - directed self-checking bench for calc_core_seq
module tb_calc_core_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [7:0]  a = 8'd0, b = 8'd0;
  logic        busy, done, neg, div_by_zero, op_err;
  logic [15:0] result;
  logic [19:0] bcd;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat;

  always #5 clk = ~clk;

  calc_core_seq #(.WIDTH(8), .BCD_DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .bcd(bcd), .neg(neg),
    .div_by_zero(div_by_zero), .op_err(op_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Issue one request and wait for done; lat = edges after the accepting edge, -1 on timeout.
  task automatic run(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                     output int n);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_bcd", {12'd0, bcd}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_flags", {29'd0, neg, div_by_zero, op_err}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run(3'd0, 8'd200, 8'd100, lat);
    chk("add_lat", lat, 32'd18);
    chk("add_result", {16'd0, result}, 32'd300);
    chk("add_bcd", {12'd0, bcd}, 32'h00300);
    chk("add_neg", {31'd0, neg}, 32'd0);

    // back-to-back: next request issued in the done cycle
    run(3'd1, 8'd5, 8'd9, lat);
    chk("sub_lat", lat, 32'd18);
    chk("sub_result", {16'd0, result}, 32'd4);
    chk("sub_neg", {31'd0, neg}, 32'd1);
    chk("sub_bcd", {12'd0, bcd}, 32'h00004);

    run(3'd1, 8'd9, 8'd9, lat);
    chk("sub_eq_result", {16'd0, result}, 32'd0);
    chk("sub_eq_neg", {31'd0, neg}, 32'd0);

    run(3'd2, 8'd255, 8'd255, lat);
    chk("mul_lat", lat, 32'd25);
    chk("mul_result", {16'd0, result}, 32'd65025);
    chk("mul_bcd", {12'd0, bcd}, 32'h65025);

    run(3'd3, 8'd200, 8'd7, lat);
    chk("div_lat", lat, 32'd25);
    chk("div_result", {16'd0, result}, 32'd28);
    chk("div_bcd", {12'd0, bcd}, 32'h00028);
    chk("div_dbz", {31'd0, div_by_zero}, 32'd0);

    run(3'd4, 8'd200, 8'd7, lat);
    chk("mod_result", {16'd0, result}, 32'd4);
    chk("mod_bcd", {12'd0, bcd}, 32'h00004);

    run(3'd3, 8'd200, 8'd0, lat);
    chk("div0_lat", lat, 32'd18);
    chk("div0_result", {16'd0, result}, 32'd255);
    chk("div0_dbz", {31'd0, div_by_zero}, 32'd1);

    run(3'd4, 8'd200, 8'd0, lat);
    chk("mod0_result", {16'd0, result}, 32'd200);
    chk("mod0_bcd", {12'd0, bcd}, 32'h00200);
    chk("mod0_dbz", {31'd0, div_by_zero}, 32'd1);

    run(3'd7, 8'd12, 8'd34, lat);
    chk("ill_lat", lat, 32'd18);
    chk("ill_err", {31'd0, op_err}, 32'd1);
    chk("ill_result", {16'd0, result}, 32'd0);
    chk("ill_dbz", {31'd0, div_by_zero}, 32'd0);

    // start while busy must be ignored
    op = 3'd2; a = 8'd255; b = 8'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    op = 3'd2; a = 8'd3; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_held", {31'd0, busy}, 32'd1);
    chk("hold_result", {16'd0, result}, 32'd0);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("ign_done_seen", {31'd0, lat > 0}, 32'd1);
    chk("ign_result", {16'd0, result}, 32'd65025);
    chk("ign_err_cleared", {31'd0, op_err}, 32'd0);
    @(posedge clk); #1;
    chk("ign_no_second", {30'd0, busy, done}, 32'd0);

    // reset in the middle of an operation
    op = 3'd2; a = 8'd7; b = 8'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", {16'd0, result}, 32'd0);
    chk("mid_rst_bcd", {12'd0, bcd}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) lat = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done || busy) lat = 1;
    end
    chk("mid_rst_no_done", lat, 32'd0);

    run(3'd0, 8'd1, 8'd2, lat);
    chk("restart_lat", lat, 32'd18);
    chk("restart_result", {16'd0, result}, 32'd3);
    chk("restart_bcd", {12'd0, bcd}, 32'h00003);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
